// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words
// and writes them at ascending addresses, holding the CPU off the memory while loading.
module imem_loader #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_load,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_write_en,
  output logic [31:0] imem_addr_wr,
  output logic [31:0] imem_data,
  output logic        imem_read_en,
  output logic        cpu_stall,
  output logic        load_done,
  output logic        load_error,
  output logic [31:0] word_count
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_word;
  logic [31:0] r_word_count;
  logic        w_start;
  logic        w_accept;
  logic        w_halt;
  logic        w_last;
  logic        w_rx_ready;
  logic        w_write_en;
  logic        w_read_en;
  logic        w_stall;
  logic        w_done;
  logic        w_error;

  assign w_halt   = (r_word == HALT_WORD);
  assign w_last   = (r_addr == LAST_ADDR);
  assign w_accept = (r_state == S_LOAD) && rx_valid;
  // start_load only counts in the resting states, so a partial word survives it
  assign w_start  = start_load &&
                    ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rx_ready = 1'b0;
    w_write_en = 1'b0;
    w_read_en  = 1'b0;
    w_stall    = 1'b0;
    w_done     = 1'b0;
    w_error    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_read_en = 1'b1;
        if (w_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_rx_ready = 1'b1;
        w_stall    = 1'b1;
        if (rx_valid && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_write_en = 1'b1;
        w_stall    = 1'b1;
        // halt takes priority: a halt word in the last slot is a clean finish
        if (w_halt)      w_next = S_DONE;
        else if (w_last) w_next = S_ERROR;
        else             w_next = S_LOAD;
      end
      S_DONE: begin
        w_read_en = 1'b1;
        w_done    = 1'b1;
        if (w_start) w_next = S_LOAD;
      end
      S_ERROR: begin
        w_stall = 1'b1;
        w_error = 1'b1;
        if (w_start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt   <= 2'd0;
      r_addr       <= 32'd0;
      r_word       <= 32'd0;
      r_word_count <= 32'd0;
    end else begin
      if (w_start) begin
        r_byte_cnt   <= 2'd0;
        r_addr       <= 32'd0;
        r_word_count <= 32'd0;
      end
      if (w_accept) begin
        r_word[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
        r_byte_cnt                        <= r_byte_cnt + 2'd1;
      end
      if (r_state == S_WRITE) begin
        r_word_count <= r_word_count + 32'd1;
        if (!w_halt && !w_last) r_addr <= r_addr + 32'd4;
      end
    end
  end

  assign rx_ready      = w_rx_ready;
  assign imem_write_en = w_write_en;
  assign imem_addr_wr  = r_addr;
  assign imem_data     = r_word;
  assign imem_read_en  = w_read_en;
  assign cpu_stall     = w_stall;
  assign load_done     = w_done;
  assign load_error    = w_error;
  assign word_count    = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized loads checked against a word-list model.
module tb_imem_loader;
  localparam int          MEM_BYTES = 1024;
  localparam logic [31:0] HALT      = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_load = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, imem_write_en, imem_read_en, cpu_stall, load_done, load_error;
  logic [31:0] imem_addr_wr, imem_data, word_count;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .start_load(start_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_write_en(imem_write_en), .imem_addr_wr(imem_addr_wr), .imem_data(imem_data),
    .imem_read_en(imem_read_en), .cpu_stall(cpu_stall), .load_done(load_done),
    .load_error(load_error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] wq[$];   // observed writes {addr, data}
  logic [63:0] eq[$];   // expected writes
  logic [31:0] wl[$];   // words offered to the loader
  bit          exp_done, exp_err;
  int          n_used;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (imem_write_en) begin
      wq.push_back({imem_addr_wr, imem_data});
      chk("wr_rd_exclusive", {31'b0, imem_read_en}, 32'd0);
      chk("rdy_low_in_write", {31'b0, rx_ready}, 32'd0);
    end
  end

  // Expected writes: word i goes to 4*i; stop on halt, else on filling the last slot.
  task automatic model();
    eq.delete(); exp_done = 0; exp_err = 0; n_used = 0;
    for (int i = 0; i < wl.size(); i++) begin
      eq.push_back({32'(4 * i), wl[i]});
      n_used++;
      if (wl[i] == HALT) begin exp_done = 1; break; end
      if (4 * i == MEM_BYTES - 4) begin exp_err = 1; break; end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
    waits = 0;
    repeat (gap) @(negedge clk) rx_valid = 1'b0;
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    while (!rx_ready && waits < 50) begin @(negedge clk); waits++; end
    if (waits >= 50) chk("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    int waits;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], $urandom_range(maxgap, 0), waits);
      if (k > 0) chk("rdy_high_in_load", waits, 0);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic run_load(input string tag, input int maxgap);
    model();
    wq.delete();
    pulse_start();
    for (int i = 0; i < n_used; i++) send_word(wl[i], maxgap);
    repeat (3) @(negedge clk);
    chk({tag, "_nwrites"}, wq.size(), eq.size());
    for (int j = 0; j < wq.size() && j < eq.size(); j++) begin
      chk({tag, "_addr"}, wq[j][63:32], eq[j][63:32]);
      chk({tag, "_data"}, wq[j][31:0], eq[j][31:0]);
    end
    chk({tag, "_done"}, {31'b0, load_done}, {31'b0, exp_done});
    chk({tag, "_error"}, {31'b0, load_error}, {31'b0, exp_err});
    chk({tag, "_wcount"}, word_count, n_used);
    chk({tag, "_stall"}, {31'b0, cpu_stall}, {31'b0, exp_err});
    chk({tag, "_read_en"}, {31'b0, imem_read_en}, {31'b0, !exp_err});
    chk({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'b0, imem_write_en}, 32'd0);
    chk({tag, "_addr"}, imem_addr_wr, 32'd0);
    chk({tag, "_data"}, imem_data, 32'd0);
    chk({tag, "_read_en"}, {31'b0, imem_read_en}, 32'd1);
    chk({tag, "_stall"}, {31'b0, cpu_stall}, 32'd0);
    chk({tag, "_done"}, {31'b0, load_done}, 32'd0);
    chk({tag, "_error"}, {31'b0, load_error}, 32'd0);
    chk({tag, "_wcount"}, word_count, 32'd0);
  endtask

  initial begin
    logic [31:0] wa, wb;
    int          waits;

    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // directed two-word load
    wl.delete(); wl.push_back(32'h20000013); wl.push_back(HALT);
    run_load("t1", 0);
    chk("t1_w0", wq.size() > 0 ? wq[0][31:0] : 32'hx, 32'h20000013);

    // random words with valid gaps, ending in halt
    wl.delete();
    for (int i = 0; i < 6; i++) wl.push_back(rnd_word());
    wl.push_back(HALT);
    run_load("t2", 3);

    // restart from DONE with a lone halt word
    wl.delete(); wl.push_back(HALT);
    run_load("t6", 2);
    chk("t6_addr0", wq.size() > 0 ? wq[0][63:32] : 32'hx, 32'h0);

    // fill memory without halt
    wl.delete();
    for (int i = 0; i < MEM_BYTES / 4; i++) wl.push_back(rnd_word());
    run_load("t3", 1);
    chk("t3_last_addr", wq.size() > 0 ? wq[wq.size()-1][63:32] : 32'hx, 32'h3FC);

    // halt lands in the last slot; also restarts from ERROR
    wl.delete();
    for (int i = 0; i < MEM_BYTES / 4 - 1; i++) wl.push_back(rnd_word());
    wl.push_back(HALT);
    run_load("t4", 1);
    chk("t4_last_addr", wq.size() > 0 ? wq[wq.size()-1][63:32] : 32'hx, 32'h3FC);

    // start_load mid-word is ignored; reset mid-word drops the partial word
    wa = rnd_word(); wb = rnd_word();
    wq.delete();
    pulse_start();
    send_byte(wa[7:0], 0, waits);
    send_byte(wa[15:8], 1, waits);
    pulse_start();
    send_byte(wa[23:16], 0, waits);
    chk("t5_rdy_after_start", waits, 0);
    send_byte(wa[31:24], 2, waits);
    send_byte(wb[7:0], 0, waits);
    send_byte(wb[15:8], 0, waits);
    @(negedge clk); reset = 1'b1;
    #1 chk_reset_vals("t5_rst");
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_nwrites", wq.size(), 1);
    chk("t5_w0", wq.size() > 0 ? wq[0][31:0] : 32'hx, wa);
    chk("t5_a0", wq.size() > 0 ? wq[0][63:32] : 32'hx, 32'h0);
    chk_reset_vals("t5_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
